// File: rtl/conv_8_32.sv
// conv_8_32 - byte-to-word packer, downstream partner of the 32->8 serialiser.
// Collects LANES valid bytes and emits one 32-bit word with a one-cycle strobe.
// Optional feature macro: PACK_GAP_TIMEOUT_EN (gap timeout discards a stalled
// partial word and pulses err). Without it a partial word waits forever.
module conv_8_32 #(
   parameter int LANES     = 4,
   parameter bit MSB_FIRST = 1'b1,
   parameter int GAP_MAX   = 3
) (
   input  logic        clk_4f,
   input  logic        reset,
   input  logic [7:0]  in_data8,
   input  logic        in8,
   output logic [31:0] out_data32,
   output logic        out32,
   output logic        err
);

   localparam int CW = (LANES > 1) ? $clog2(LANES) : 1;
   localparam logic [CW-1:0] LAST = CW'(LANES - 1);

   // The word width is fixed at 32 bits; catch bad parameter overrides early.
   if (8 * LANES != 32) begin : g_lanes_chk
      $error("conv_8_32: LANES must be 4");
   end
   if (GAP_MAX < 1) begin : g_gap_chk
      $error("conv_8_32: GAP_MAX must be >= 1");
   end

   logic [CW-1:0] cnt_q, cnt_d;     // byte counter: 0 = EMPTY, else PARTIAL
   logic [31:0]   asm_q, asm_d;     // assembly register, never cleared between words
   logic [31:0]   out_q, out_d;
   logic          out32_q, out32_d;

`ifdef PACK_GAP_TIMEOUT_EN
   localparam int GW = $clog2(GAP_MAX + 1);
   localparam logic [GW-1:0] GAP_LAST = GW'(GAP_MAX - 1);
   logic [GW-1:0] gap_q, gap_d;
   logic          err_q, err_d;
`endif

   // Next-state: place the byte in its lane, complete the word on the last lane,
   // and (optionally) discard a partial word after too many idle cycles.
   always_comb begin
      int lane;
      lane    = MSB_FIRST ? (LANES - 1 - int'(cnt_q)) : int'(cnt_q);
      asm_d   = asm_q;
      cnt_d   = cnt_q;
      out_d   = out_q;
      out32_d = 1'b0;
`ifdef PACK_GAP_TIMEOUT_EN
      gap_d   = '0;
      err_d   = 1'b0;
`endif
      if (in8) begin
         asm_d[8*lane +: 8] = in_data8;
         if (cnt_q == LAST) begin
            out_d   = asm_d;            // includes the byte arriving this edge
            out32_d = 1'b1;
            cnt_d   = '0;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
`ifdef PACK_GAP_TIMEOUT_EN
      // A byte arriving on the would-be timeout edge wins: it is accepted above
      // and the gap count clears.
      else if (cnt_q != '0) begin
         if (gap_q == GAP_LAST) begin
            cnt_d = '0;               // stale bytes stay in asm_q; lanes are rewritten
            err_d = 1'b1;
         end else begin
            gap_d = gap_q + 1'b1;
         end
      end
`endif
   end

   // State registers; reset dominates in8 and silently drops a partial word.
   always_ff @(posedge clk_4f) begin
      if (reset) begin
         cnt_q   <= '0;
         asm_q   <= '0;
         out_q   <= '0;
         out32_q <= 1'b0;
`ifdef PACK_GAP_TIMEOUT_EN
         gap_q   <= '0;
         err_q   <= 1'b0;
`endif
      end else begin
         cnt_q   <= cnt_d;
         asm_q   <= asm_d;
         out_q   <= out_d;
         out32_q <= out32_d;
`ifdef PACK_GAP_TIMEOUT_EN
         gap_q   <= gap_d;
         err_q   <= err_d;
`endif
      end
   end

   assign out_data32 = out_q;
   assign out32      = out32_q;
`ifdef PACK_GAP_TIMEOUT_EN
   assign err        = err_q;
`else
   assign err        = 1'b0;
`endif

endmodule

// File: tb/tb_conv_8_32.sv
// Directed bench for conv_8_32. Inputs change on the falling edge; outputs are
// checked on the falling edge, so a check right after drv() sees the result of
// the rising edge that consumed the previous drv() values.
module tb_conv_8_32;

   logic        clk_4f = 1'b0;
   logic        reset  = 1'b1;
   logic [7:0]  in_data8 = '0;
   logic        in8 = 1'b0;
   logic [31:0] out_m, out_l;
   logic        s_m, s_l, err_m, err_l;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk_4f = ~clk_4f;

   conv_8_32 #(.LANES(4), .MSB_FIRST(1'b1), .GAP_MAX(3)) u_msb (
      .clk_4f(clk_4f), .reset(reset), .in_data8(in_data8), .in8(in8),
      .out_data32(out_m), .out32(s_m), .err(err_m));

   conv_8_32 #(.LANES(4), .MSB_FIRST(1'b0), .GAP_MAX(3)) u_lsb (
      .clk_4f(clk_4f), .reset(reset), .in_data8(in_data8), .in8(in8),
      .out_data32(out_l), .out32(s_l), .err(err_l));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic drv(input logic v, input logic [7:0] b, input logic r = 1'b0);
      @(negedge clk_4f);
      reset    = r;
      in8      = v;
      in_data8 = b;
   endtask

   task automatic rst();
      drv(1'b0, 8'h00, 1'b1);
      drv(1'b0, 8'h00);
   endtask

   logic [31:0] words [4] = '{32'h12345678, 32'hDEADBEEF, 32'h00FF00FF, 32'h80000001};

   initial begin
      // 1: reset, then idle
      rst();
      for (int i = 0; i < 3; i++) begin
         drv(1'b0, 8'h00);
         chk("t1_data", out_m, 32'h0);
         chk("t1_strobe", {31'b0, s_m}, 32'h0);
         chk("t1_err", {31'b0, err_m}, 32'h0);
      end

      // 2: FF x4 back-to-back
      for (int i = 0; i < 4; i++) begin
         drv(1'b1, 8'hFF);
         if (i > 0) chk("t2_no_early_strobe", {31'b0, s_m}, 32'h0);
      end
      drv(1'b0, 8'h00);
      chk("t2_data", out_m, 32'hFFFFFFFF);
      chk("t2_strobe", {31'b0, s_m}, 32'h1);
      drv(1'b0, 8'h00);
      chk("t2_strobe_drop", {31'b0, s_m}, 32'h0);
      chk("t2_hold", out_m, 32'hFFFFFFFF);

      // 3: DD x4 then 00,00,00,03 contiguous
      rst();
      for (int i = 0; i < 4; i++) drv(1'b1, 8'hDD);
      drv(1'b1, 8'h00);
      chk("t3_w1_strobe", {31'b0, s_m}, 32'h1);
      chk("t3_w1_data", out_m, 32'hDDDDDDDD);
      drv(1'b1, 8'h00);
      chk("t3_gap_strobe", {31'b0, s_m}, 32'h0);
      drv(1'b1, 8'h00);
      drv(1'b1, 8'h03);
      chk("t3_hold", out_m, 32'hDDDDDDDD);
      drv(1'b0, 8'h00);
      chk("t3_w2_strobe", {31'b0, s_m}, 32'h1);
      chk("t3_w2_data", out_m, 32'h00000003);

      // 4: LSB-first with 2 idle cycles mid-word (below GAP_MAX)
      rst();
      drv(1'b1, 8'h11);
      drv(1'b1, 8'h22);
      drv(1'b0, 8'h00);
      drv(1'b0, 8'h00);
      drv(1'b1, 8'h33);
      chk("t4_err", {31'b0, err_l}, 32'h0);
      drv(1'b1, 8'h44);
      chk("t4_no_early_strobe", {31'b0, s_l}, 32'h0);
      drv(1'b0, 8'h00);
      chk("t4_lsb_data", out_l, 32'h44332211);
      chk("t4_lsb_strobe", {31'b0, s_l}, 32'h1);
      chk("t4_msb_data", out_m, 32'h11223344);
      chk("t4_err_end", {31'b0, err_l}, 32'h0);

      // 5: AA,BB, 3 idle, then 01..04
      rst();
      drv(1'b1, 8'hAA);
      drv(1'b1, 8'hBB);
      drv(1'b0, 8'h00);
      drv(1'b0, 8'h00);
      drv(1'b0, 8'h00);
      drv(1'b1, 8'h01);
`ifdef PACK_GAP_TIMEOUT_EN
      chk("t5_err_pulse", {31'b0, err_m}, 32'h1);
      drv(1'b1, 8'h02);
      chk("t5_err_drop", {31'b0, err_m}, 32'h0);
      drv(1'b1, 8'h03);
      drv(1'b1, 8'h04);
      chk("t5_no_strobe", {31'b0, s_m}, 32'h0);
      drv(1'b0, 8'h00);
      chk("t5_data", out_m, 32'h01020304);
      chk("t5_strobe", {31'b0, s_m}, 32'h1);
`else
      chk("t5_err_tied", {31'b0, err_m}, 32'h0);
      drv(1'b1, 8'h02);
      drv(1'b0, 8'h00);
      chk("t5_wait_data", out_m, 32'hAABB0102);
      chk("t5_wait_strobe", {31'b0, s_m}, 32'h1);
`endif

      // 5b: byte arrives on the edge the gap count would hit GAP_MAX
      rst();
      drv(1'b1, 8'hAA);
      drv(1'b0, 8'h00);
      drv(1'b0, 8'h00);
      drv(1'b1, 8'hBB);
      drv(1'b1, 8'hCC);
      chk("t5b_err", {31'b0, err_m}, 32'h0);
      drv(1'b1, 8'hDD);
      drv(1'b0, 8'h00);
      chk("t5b_data", out_m, 32'hAABBCCDD);
      chk("t5b_strobe", {31'b0, s_m}, 32'h1);

      // 6: reset after 2 bytes (reset beats in8), then 12,34,56,78
      drv(1'b1, 8'hEE);
      drv(1'b1, 8'hEE);
      drv(1'b1, 8'hEE, 1'b1);
      drv(1'b1, 8'h12);
      chk("t6_reset_data", out_m, 32'h0);
      chk("t6_reset_strobe", {31'b0, s_m}, 32'h0);
      drv(1'b1, 8'h34);
      drv(1'b1, 8'h56);
      drv(1'b1, 8'h78);
      chk("t6_no_strobe", {31'b0, s_m}, 32'h0);
      drv(1'b0, 8'h00);
      chk("t6_data", out_m, 32'h12345678);
      chk("t6_strobe", {31'b0, s_m}, 32'h1);
      chk("t6_err", {31'b0, err_m}, 32'h0);

      // 7: serialised words (MSB byte first) back-to-back, reproduced in order
      rst();
      for (int k = 0; k < 4; k++) begin
         for (int b = 0; b < 4; b++) begin
            drv(1'b1, words[k][31-8*b -: 8]);
            if (b == 0 && k > 0) begin
               chk("t7_data", out_m, words[k-1]);
               chk("t7_strobe", {31'b0, s_m}, 32'h1);
            end else if (b == 1) begin
               chk("t7_no_strobe", {31'b0, s_m}, 32'h0);
            end
         end
      end
      drv(1'b0, 8'h00);
      chk("t7_last_data", out_m, words[3]);
      chk("t7_last_strobe", {31'b0, s_m}, 32'h1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
